layer_sequencer: RTL and testbench
==================================

# layer_sequencer

Controller that sequences one fully-connected layer around the one-hot-addressed weight ROM. On `start` it latches the input activations, walks the ROM address one-hot across all input neurons, and multiply-accumulates each returned weight row into `NEURONS_OUT` signed accumulators. It then presents the layer result with a `done` pulse. It sits between two layers of the network datapath, and one instance drives one ROM layer instance.

## Interface
- `W_SIZE`, 8, weight width in bits, signed two's complement.
- `A_SIZE`, 8, activation width in bits, signed two's complement.
- `NEURONS_IN`, 4, input neuron count, ≥2; sets the one-hot address width.
- `NEURONS_OUT`, 8, output neuron count.
- `ACC_SIZE`, `W_SIZE+A_SIZE+$clog2(NEURONS_IN)`, accumulator width. This width guarantees no overflow.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a layer pass; accepted only in IDLE.
- `act_in` in `NEURONS_IN*A_SIZE`: input activations; neuron i occupies bits `[i*A_SIZE +: A_SIZE]`.
- `rom_addr` out `NEURONS_IN`: one-hot ROM address, or all-zero when idle.
- `rom_data` in `NEURONS_OUT*W_SIZE`: combinational ROM row; output neuron j occupies bits `[j*W_SIZE +: W_SIZE]`.
- `busy` out 1: high from acceptance until `done`, inclusive.
- `done` out 1: one-cycle pulse when the result is final.
- `acc_out` out `NEURONS_OUT*ACC_SIZE`: accumulated results, neuron j at bits `[j*ACC_SIZE +: ACC_SIZE]`.

## Operation
- FSM states: IDLE, CLEAR, ACCUM, DONE.
- **IDLE:** on `start`=1, latch `act_in` into `act_q` and go to CLEAR.
- **CLEAR:** zero all accumulators, set step counter k=0, go to ACCUM.
- **ACCUM:** each cycle:
  - drive `rom_addr = 1<<k`;
  - for all j, `acc[j] += sext(rom_data[j]) * sext(act_q[k])`, full signed product sign-extended to `ACC_SIZE`.
  - If k==`NEURONS_IN-1`, go to DONE; otherwise k++.
- **DONE:** assert `done` for one cycle and return to IDLE.
- `acc_out` holds its value from DONE until the next CLEAR. Accumulators are not cleared on return to IDLE.
- `start` while `busy` is ignored; no queueing.
- `start` arriving in the same cycle as DONE is ignored. It is accepted only when sampled in IDLE.
- Changes on `act_in` after acceptance have no effect on the current pass.
- Reset mid-pass aborts immediately; no `done` is issued for the aborted pass.
- `rom_addr` is registered-state-derived, never glitching between steps, and exactly one bit is high in ACCUM.

## Timing
- Reset values: state=IDLE, `rom_addr`=0, `busy`=0, `done`=0, `acc_out`=0, k=0, `act_q`=0.
- Cycle T is the cycle `start` is sampled high in IDLE:
  - T+1: CLEAR, with `busy`=1.
  - T+2 … T+1+`NEURONS_IN`: ACCUM.
  - T+2+`NEURONS_IN`: DONE, with `done`=1 and `acc_out` final.
- Latency from start to done is `NEURONS_IN+2` cycles. Back-to-back throughput is one pass per `NEURONS_IN+3` cycles.
- The ROM is combinational, so `rom_data` is used in the same cycle `rom_addr` is driven. There is no ROM wait state.

## Configuration
- `LAYER_SEQ_RELU_EN`
  - Defined: in DONE and afterwards, `acc_out[j]` = 0 wherever `acc[j]` < 0; otherwise pass-through. The clamp is applied combinationally on the output; internal accumulators are unchanged.
  - Undefined: `acc_out` is the raw signed accumulator.

## Structure
- Shared package `network_pkg`: FSM state enum typedef `layer_seq_state_t`, and a function computing the default `ACC_SIZE`.
- Weight contents stay in the existing weights package.
- One sub-module, `layer_mac_lane`: a single accumulator with clear and enable, taking a signed weight and activation. Instantiate it `NEURONS_OUT` times with generate.

## Test plan
- **Basic pass.** Setup: defaults; ROM row i all weights = i+1; `act_in` = {4,3,2,1} for neurons 3..0; pulse `start`.
  - Every `acc_out[j]` = 1·1+2·2+3·3+4·4 = 30.
  - `done` occurs exactly 6 cycles after `start`.
  - `rom_addr` sequence is 0001, 0010, 0100, 1000.
- **Signed extremes.** Setup: all weights = −128, all activations = −128.
  - Each acc = 4·16384 = 65536, with no overflow at `ACC_SIZE`=18.
  - With weights = 127 and activations = −128, each acc = −65024.
- **ReLU.** Same data as the negative case of signed extremes.
  - With `LAYER_SEQ_RELU_EN` defined: `acc_out` = 0.
  - Without it: `acc_out` = −65024 (18-bit two's complement).
- **Ignored start and activation change.** Pulse `start` and change `act_in` at T+3 mid-pass.
  - The result equals the original activations.
  - Exactly one `done` is produced.
  - `start` at the DONE cycle is ignored.
- **Reset mid-pass.** Assert `rst` at T+3.
  - Next cycle: `busy`=0, `rom_addr`=0, `acc_out`=0.
  - No `done` pulse.
  - A new `start` afterwards yields the correct result.
- **Back-to-back.** Issue a second `start` in the first IDLE cycle after `done`, with new activations {1,0,0,0}.
  - The result is row-3 weights × 1.
  - `acc_out` holds the previous value through CLEAR.

Source files
------------

// File: rtl/network_pkg.sv
// ----------------------------------------------------------------------------
// network_pkg
//
// Purpose: types and helpers shared by the network datapath blocks.
//   - layer_seq_state_t : state encoding of the layer_sequencer FSM
//   - acc_size()        : default accumulator width for a fully-connected
//                         layer, wide enough that a full pass can never
//                         overflow
//
// Ports: none (package).
// ----------------------------------------------------------------------------
package network_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } layer_seq_state_t;

    // Each product needs w_size+a_size bits. Summing neurons_in of them
    // grows the result by at most clog2(neurons_in) bits.
    function automatic int acc_size(input int w_size,
                                    input int a_size,
                                    input int neurons_in);
        return w_size + a_size + $clog2(neurons_in);
    endfunction

endpackage

// File: rtl/layer_mac_lane.sv
// ----------------------------------------------------------------------------
// layer_mac_lane
//
// Purpose: a single signed multiply-accumulate lane. Each enabled cycle it
//          adds weight*act to its accumulator. A clear zeroes it and has
//          priority over enable.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (accumulator -> 0)
//   clear  in   zero the accumulator on the next edge
//   en     in   accumulate weight*act on the next edge
//   weight in   signed weight, W_SIZE bits
//   act    in   signed activation, A_SIZE bits
//   acc    out  signed accumulator, ACC_SIZE bits
//
// ACC_SIZE must be strictly larger than W_SIZE+A_SIZE.
// ----------------------------------------------------------------------------
module layer_mac_lane #(
    parameter int W_SIZE   = 8,
    parameter int A_SIZE   = 8,
    parameter int ACC_SIZE = 18
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       en,
    input  logic signed [W_SIZE-1:0]   weight,
    input  logic signed [A_SIZE-1:0]   act,
    output logic signed [ACC_SIZE-1:0] acc
);

    localparam int P_SIZE = W_SIZE + A_SIZE;

    logic signed [P_SIZE-1:0]   weight_ext;
    logic signed [P_SIZE-1:0]   act_ext;
    logic signed [P_SIZE-1:0]   product;
    logic signed [ACC_SIZE-1:0] product_ext;
    logic signed [ACC_SIZE-1:0] acc_q;
    logic signed [ACC_SIZE-1:0] acc_d;

    // Both operands are sign-extended to the full product width first.
    // The low P_SIZE bits of that multiply are then the exact signed product.
    assign weight_ext  = {{A_SIZE{weight[W_SIZE-1]}}, weight};
    assign act_ext     = {{W_SIZE{act[A_SIZE-1]}}, act};
    assign product     = weight_ext * act_ext;
    assign product_ext = {{(ACC_SIZE-P_SIZE){product[P_SIZE-1]}}, product};

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + product_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/layer_sequencer.sv
// ----------------------------------------------------------------------------
// layer_sequencer
//
// Purpose: sequences one fully-connected layer around a one-hot-addressed,
//          combinational weight ROM.
//   1. On start in IDLE it latches the activations.
//   2. It clears the accumulators.
//   3. It walks the ROM address one-hot over the NEURONS_IN input neurons.
//      Each returned weight row is multiply-accumulated into NEURONS_OUT lanes.
//   4. It pulses done.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset; aborts a pass in flight
//   start     in   request a pass; accepted only when sampled in IDLE
//   act_in    in   activations, neuron i at [i*A_SIZE +: A_SIZE]
//   rom_addr  out  one-hot ROM row select, all-zero outside ACCUM
//   rom_data  in   ROM row, output neuron j at [j*W_SIZE +: W_SIZE]
//   busy      out  high from CLEAR through DONE
//   done      out  one-cycle pulse when acc_out is final
//   acc_out   out  results, neuron j at [j*ACC_SIZE +: ACC_SIZE]
//
// Configuration macro: LAYER_SEQ_RELU_EN
//   defined   - negative results read as zero on acc_out once the pass is
//               final. The internal accumulators keep the signed value.
//   undefined - acc_out is the raw signed accumulator.
// ----------------------------------------------------------------------------
module layer_sequencer
    import network_pkg::*;
#(
    parameter int W_SIZE      = 8,
    parameter int A_SIZE      = 8,
    parameter int NEURONS_IN  = 4,
    parameter int NEURONS_OUT = 8,
    parameter int ACC_SIZE    = acc_size(W_SIZE, A_SIZE, NEURONS_IN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NEURONS_IN*A_SIZE-1:0]    act_in,
    output logic [NEURONS_IN-1:0]           rom_addr,
    input  logic [NEURONS_OUT*W_SIZE-1:0]   rom_data,
    output logic                            busy,
    output logic                            done,
    output logic [NEURONS_OUT*ACC_SIZE-1:0] acc_out
);

    localparam int              K_W    = $clog2(NEURONS_IN);
    localparam logic [K_W-1:0]  K_LAST = K_W'(NEURONS_IN - 1);

    layer_seq_state_t               state_q, state_d;
    logic [K_W-1:0]                 k_q, k_d;
    logic [NEURONS_IN*A_SIZE-1:0]   act_q, act_d;

    logic [A_SIZE-1:0]              act_arr [NEURONS_IN];
    logic signed [A_SIZE-1:0]       cur_act;
    logic signed [ACC_SIZE-1:0]     acc_raw [NEURONS_OUT];
    logic                           lane_clear;
    logic                           lane_en;

    // ------------------------------------------------------------------
    // Next-state logic. The activations are only captured on acceptance,
    // so later changes on act_in cannot reach the pass in flight.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        act_d   = act_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    act_d   = act_in;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                k_d     = '0;
                state_d = ACCUM;
            end
            ACCUM: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            act_q   <= act_d;
        end
    end

    // ------------------------------------------------------------------
    // Status and ROM address come straight from registered state. The
    // address therefore changes only at clock edges, and it has exactly
    // one bit set throughout ACCUM.
    // ------------------------------------------------------------------
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_comb begin
        rom_addr = '0;
        if (state_q == ACCUM) begin
            rom_addr[k_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // MAC lanes. All lanes share the activation of the current step.
    // Each lane takes its own weight from the ROM row.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NEURONS_IN; i++) begin : g_act
        assign act_arr[i] = act_q[i*A_SIZE +: A_SIZE];
    end

    assign cur_act    = act_arr[k_q];
    assign lane_clear = (state_q == CLEAR);
    assign lane_en    = (state_q == ACCUM);

    for (genvar j = 0; j < NEURONS_OUT; j++) begin : g_lane
        layer_mac_lane #(
            .W_SIZE   (W_SIZE),
            .A_SIZE   (A_SIZE),
            .ACC_SIZE (ACC_SIZE)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clear  (lane_clear),
            .en     (lane_en),
            .weight (rom_data[j*W_SIZE +: W_SIZE]),
            .act    (cur_act),
            .acc    (acc_raw[j])
        );
    end

    // ------------------------------------------------------------------
    // Output view. With ReLU enabled, the clamp is skipped while ACCUM is
    // summing partial results. It applies in DONE and in every later
    // state, so the value shown at DONE is held unchanged until the next
    // CLEAR.
    // ------------------------------------------------------------------
`ifdef LAYER_SEQ_RELU_EN
    logic relu_active;
    assign relu_active = (state_q != ACCUM);

    always_comb begin
        acc_out = '0;
        for (int j = 0; j < NEURONS_OUT; j++) begin
            if (relu_active && acc_raw[j][ACC_SIZE-1]) begin
                acc_out[j*ACC_SIZE +: ACC_SIZE] = '0;
            end else begin
                acc_out[j*ACC_SIZE +: ACC_SIZE] = acc_raw[j];
            end
        end
    end
`else
    always_comb begin
        acc_out = '0;
        for (int j = 0; j < NEURONS_OUT; j++) begin
            acc_out[j*ACC_SIZE +: ACC_SIZE] = acc_raw[j];
        end
    end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_layer_sequencer
//
// Scoreboarded bench for layer_sequencer. Each accepted start pushes the
// expected result and done cycle. A forked monitor pops and compares on
// every done pulse. Follows LAYER_SEQ_RELU_EN when the macro is defined.
// ----------------------------------------------------------------------------
module tb_layer_sequencer;

    localparam int W    = 8;
    localparam int A    = 8;
    localparam int NI   = 4;
    localparam int NO   = 8;
    localparam int ACC  = 18;
    localparam int OUTW = NO * ACC;
    localparam int ACTW = NI * A;
    localparam int LAT  = NI + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [ACTW-1:0] act_in;
    logic [NI-1:0]   rom_addr;
    logic [NO*W-1:0] rom_data;
    logic            busy;
    logic            done;
    logic [OUTW-1:0] acc_out;

    logic [NO*W-1:0] rom_rows [NI];

    int cyc        = 0;
    int checks     = 0;
    int errors     = 0;
    int done_count = 0;

    typedef struct {
        logic [OUTW-1:0] acc;
        int              cyc;
    } exp_t;

    exp_t          sb[$];
    logic [NI-1:0] addr_log[$];

    layer_sequencer #(
        .W_SIZE      (W),
        .A_SIZE      (A),
        .NEURONS_IN  (NI),
        .NEURONS_OUT (NO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .act_in   (act_in),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .done     (done),
        .acc_out  (acc_out)
    );

    // Clock and free-running cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ROM: returns the row whose address bit is set
    always_comb begin
        rom_data = '0;
        for (int i = 0; i < NI; i++) begin
            if (rom_addr[i]) rom_data = rom_rows[i];
        end
    end

    // Reference model: dot product of every weight column with the activations
    function automatic logic [OUTW-1:0] model(input logic [ACTW-1:0] act);
        logic [OUTW-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < NO; j++) begin
            s = 0;
            for (int i = 0; i < NI; i++) begin
                s += int'($signed(rom_rows[i][j*W +: W])) * int'($signed(act[i*A +: A]));
            end
`ifdef LAYER_SEQ_RELU_EN
            if (s < 0) s = 0;
`endif
            r[j*ACC +: ACC] = s[ACC-1:0];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) next_cycle();
    endtask

    task automatic applyStimulus(input logic [ACTW-1:0] act, input logic st);
        act_in = act;
        start  = st;
    endtask

    // Drive start for one cycle from IDLE and record the expected response
    task automatic start_pass(input logic [ACTW-1:0] act);
        exp_t e;
        applyStimulus(act, 1'b1);
        e.acc = model(act);
        e.cyc = cyc + LAT;
        sb.push_back(e);
        next_cycle();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            next_cycle();
            n++;
        end
        checkOutput({name, "_completion"}, (sb.size() == 0 && !busy), 1);
    endtask

    task automatic set_all_weights(input logic [W-1:0] w);
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                rom_rows[i][j*W +: W] = w;
    endtask

    task automatic set_rows_by_index();
        for (int i = 0; i < NI; i++)
            for (int j = 0; j < NO; j++)
                rom_rows[i][j*W +: W] = W'(i + 1);
    endtask

    task automatic randomize_rows();
        for (int i = 0; i < NI; i++) rom_rows[i] = {$urandom, $urandom};
    endtask

    // Monitor: pops the scoreboard on each done pulse
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("rom_addr_onehot", ($countones(rom_addr) <= 1), 1);
                if (rom_addr != '0) addr_log.push_back(rom_addr);
                if (done) begin
                    done_count++;
                    if (sb.size() == 0) begin
                        checkOutput("spurious_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("acc_out", acc_out, e.acc);
                        checkOutput("done_cycle", cyc, e.cyc);
                        checkOutput("busy_at_done", busy, 1);
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int dc;
        int w;
        logic [ACTW-1:0] a1;
        logic [OUTW-1:0] prev;
        logic [ACC-1:0] neg_exp;

        rst = 1'b1;
        start = 1'b0;
        act_in = '0;
        set_rows_by_index();
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) next_cycle();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_rom_addr", rom_addr, 0);
        checkOutput("reset_acc_out", acc_out, 0);
        rst = 1'b0;
        next_cycle();

        // Basic pass: row i weights = i+1, activations {4,3,2,1}
        addr_log.delete();
        start_pass({8'd4, 8'd3, 8'd2, 8'd1});
        wait_idle("basic");
        checkOutput("basic_addr_count", addr_log.size(), 4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++)
            checkOutput("basic_addr_seq", addr_log[k], 1 << k);
        for (int j = 0; j < NO; j++)
            checkOutput("basic_lane", acc_out[j*ACC +: ACC], 30);

        // Signed extremes
        set_all_weights(8'h80);
        start_pass({4{8'h80}});
        wait_idle("extreme_pos");
        checkOutput("extreme_pos_lane0", acc_out[ACC-1:0], 18'd65536);

        set_all_weights(8'h7f);
        start_pass({4{8'h80}});
        wait_idle("extreme_neg");
`ifdef LAYER_SEQ_RELU_EN
        neg_exp = '0;
`else
        neg_exp = ACC'(-65024);
`endif
        checkOutput("extreme_neg_lane0", acc_out[ACC-1:0], neg_exp);
        checkOutput("extreme_neg_lane7", acc_out[7*ACC +: ACC], neg_exp);

        // Ignored mid-pass start / act change, and start in the DONE cycle
        set_rows_by_index();
        n = cyc;
        dc = done_count;
        start_pass({8'd4, 8'd3, 8'd2, 8'd1});
        wait_until(n + 3);
        applyStimulus({8'd9, 8'd7, 8'd5, 8'd3}, 1'b1);
        next_cycle();
        start = 1'b0;
        wait_until(n + 6);
        checkOutput("ignored_done_cycle", done, 1);
        applyStimulus({8'd1, 8'd1, 8'd1, 8'd1}, 1'b1);
        next_cycle();
        start = 1'b0;
        repeat (10) next_cycle();
        checkOutput("ignored_single_done", done_count - dc, 1);
        checkOutput("ignored_idle_after", busy, 0);

        // Reset mid-pass
        randomize_rows();
        n = cyc;
        dc = done_count;
        start_pass($urandom);
        wait_until(n + 3);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        sb.delete();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rom_addr", rom_addr, 0);
        checkOutput("abort_acc_out", acc_out, 0);
        repeat (10) next_cycle();
        checkOutput("abort_no_done", done_count - dc, 0);
        start_pass($urandom);
        wait_idle("after_abort");

        // Back-to-back: second start in the first IDLE cycle after done
        randomize_rows();
        a1 = $urandom;
        prev = model(a1);
        n = cyc;
        start_pass(a1);
        wait_until(n + 7);
        checkOutput("b2b_idle", busy, 0);
        start_pass({8'd1, 24'd0});
        checkOutput("b2b_busy_clear", busy, 1);
        checkOutput("b2b_hold_clear", acc_out, prev);
        wait_idle("b2b");
        for (int j = 0; j < NO; j++) begin
            w = int'($signed(rom_rows[3][j*W +: W]));
`ifdef LAYER_SEQ_RELU_EN
            if (w < 0) w = 0;
`endif
            checkOutput("b2b_row3", acc_out[j*ACC +: ACC], w[ACC-1:0]);
        end

        // Randomized passes with noise on start/act_in while busy
        for (int t = 0; t < 20; t++) begin
            randomize_rows();
            start_pass($urandom);
            for (int c = 0; c < 5; c++) begin
                applyStimulus($urandom, 1'($urandom_range(0, 1)));
                next_cycle();
            end
            start = 1'b0;
            wait_idle("random");
            repeat ($urandom_range(0, 3)) next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
